alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Sequencer and round-robin arbiter that shares the single combinational 32-bit ALU (add, sub, and, or, nor; 33-bit sign-extended result) among NREQ requesters. Each requester presents operands and an operation with a valid/ready handshake. The block registers the granted request, drives the ALU for one cycle, captures the result, and returns it with the requester id over a backpressured response channel. It sits between the requesting units and the ALU. The ALU instance is external and connected through the alu_* ports.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, operand width; result width is WIDTH+1
- IDW, 2, id width, equal to ceil(log2(NREQ))

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request valid, one bit per requester
- req_ready  out  NREQ  grant/accept, one-hot or zero
- req_a  in  NREQ*WIDTH  operand a; requester i uses slice [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand b, sliced as req_a
- req_op  in  NREQ*3  op code {s2,s1,s0}; requester i uses slice [i*3 +: 3]
- alu_a  out  WIDTH  ALU operand a, registered
- alu_b  out  WIDTH  ALU operand b, registered
- alu_op  out  3  ALU select {s2,s1,s0}, registered
- alu_res  in  WIDTH+1  ALU result, combinational from alu_a/alu_b/alu_op
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  requester index of the response
- rsp_res  out  WIDTH+1  captured result
- rsp_err  out  1  illegal op code flag
- busy  out  1  high whenever state is not IDLE
- op_count  out  16  count of completed legal operations; wraps

## Operation
- Op codes: 000 add, 001 sub (a-b), 010 and, 011 or, 100 nor. Codes 101, 110 and 111 are illegal.
- States: IDLE, EXEC, DONE.
- IDLE:
  - If any req_valid bit is set, the arbiter picks grant g. Search order is ptr, ptr+1, … mod NREQ.
  - req_ready[g] is asserted combinationally in the same cycle. All other req_ready bits are 0.
  - At the clock edge, the block latches a, b, op and id from requester g, and sets ptr to (g+1) mod NREQ.
  - If op is legal: alu_a, alu_b and alu_op load the granted values, and the next state is EXEC.
  - If op is illegal: alu_* keep their previous values, rsp_res is set to 0, rsp_err to 1, rsp_id to g, and the next state is DONE.
- EXEC (one cycle):
  - alu_* are stable.
  - At the edge, rsp_res captures alu_res unmodified, with rsp_err=0 and rsp_id set to the latched id.
  - op_count increments, wrapping from 0xFFFF to 0.
  - Next state is DONE.
- DONE:
  - rsp_valid=1. rsp_* are held stable until rsp_valid && rsp_ready.
  - On that handshake edge, the next state is IDLE and rsp_valid drops.
- req_ready is 0 in EXEC and DONE. No new request is accepted before the response handshake completes.
- Requesters keep req_valid and their operands asserted until req_ready. The arbiter is not required to hold a grant across cycles if req_valid drops before acceptance.

## Timing
- Reset (async assert, synchronous deassert by system) sets:
  - state IDLE, ptr=0
  - req_ready=0, alu_a=0, alu_b=0, alu_op=000
  - rsp_valid=0, rsp_id=0, rsp_res=0, rsp_err=0
  - busy=0, op_count=0
- Reset mid-operation discards the in-flight request. No response is produced.
- Legal op: if accepted at edge T, rsp_valid rises after edge T+1 and is visible in cycle T+2.
- Illegal op: rsp_valid is visible in cycle T+1.
- If rsp_ready is high in the first DONE cycle, IDLE is reached one cycle later. Peak throughput is one legal op per 3 cycles.
- A request presented in the cycle rsp_valid falls is eligible in the next (IDLE) cycle.
- Width rule: rsp_res[WIDTH] equals alu_res[WIDTH], passed through unmodified. No arithmetic is done in this block.

## Test plan
- Single add: req0 a=5, b=7, op=000, rsp_ready=1. Expected: req_ready[0] in the request cycle; rsp_valid 2 cycles later with rsp_res=33'h0_0000000C, rsp_id=0, rsp_err=0; op_count=1.
- Negative sub: req2 a=3, b=5, op=001. Expected: rsp_res=33'h1_FFFFFFFE, rsp_id=2.
- Round robin: all four req_valid held high continuously, rsp_ready=1. Expected: grant order 0,1,2,3,0,1; one grant every 3 cycles; op_count=6 after six responses.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid. Expected: rsp_id, rsp_res and rsp_valid stable; req_ready stays 0 with req1 valid. Then raise rsp_ready: req1 is granted the cycle after rsp_valid falls.
- Illegal op: req3 op=110, a=1, b=1. Expected: rsp_valid the next cycle with rsp_err=1, rsp_res=0, rsp_id=3; op_count unchanged; alu_op unchanged.
- Reset in EXEC: assert rst_n=0 during EXEC of a nor op. Expected: all outputs go to reset values immediately and no rsp_valid follows. After release, req0 is granted first (ptr=0).

Source files
------------

// File: rtl/alu_share_ctrl_if.sv
// ----------------------------------------------------------------------------
// alu_share_ctrl_if : request/response channels of the shared-ALU sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface alu_share_ctrl_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*3-1:0]     req_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH:0]        rsp_res;
  logic                  rsp_err;

  // Requester / response-consumer side
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_res, rsp_err
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_res, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/alu_share_ctrl.sv
// ----------------------------------------------------------------------------
// alu_share_ctrl : round-robin sequencer sharing one external combinational ALU
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_share_ctrl #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = 2
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  alu_share_ctrl_if.slave        bus,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [2:0]             alu_op,
  input  wire logic [WIDTH:0]    alu_res,
  output logic                   busy,
  output logic [15:0]            op_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0]   c_OP_LAST   = 3'b100;
  localparam logic [IDW:0] c_NREQ_EXT  = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] c_ID_LAST = IDW'(NREQ - 1);

  state_t              r_state;
  state_t              w_state_nxt;

  logic [IDW-1:0]      r_ptr;
  logic [IDW-1:0]      r_id;
  logic [WIDTH-1:0]    r_alu_a;
  logic [WIDTH-1:0]    r_alu_b;
  logic [2:0]          r_alu_op;
  logic [WIDTH:0]      r_rsp_res;
  logic [IDW-1:0]      r_rsp_id;
  logic                r_rsp_err;
  logic [15:0]         r_op_count;

  logic                w_found;
  logic [IDW-1:0]      w_gnt;
  logic [IDW:0]        w_sum;
  logic [IDW-1:0]      w_ptr_nxt;
  logic [WIDTH-1:0]    w_sel_a;
  logic [WIDTH-1:0]    w_sel_b;
  logic [2:0]          w_sel_op;
  logic                w_legal;
  logic                w_accept;
  logic [NREQ-1:0]     w_req_ready;

  // Round-robin search starting at r_ptr; offsets wrap modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_sum >= c_NREQ_EXT) begin
        w_sum = w_sum - c_NREQ_EXT;
      end
      if (!w_found && bus.req_valid[w_sum[IDW-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt == IDW'(i)) begin
        w_sel_a  = bus.req_a[i*WIDTH +: WIDTH];
        w_sel_b  = bus.req_b[i*WIDTH +: WIDTH];
        w_sel_op = bus.req_op[i*3 +: 3];
      end
    end
  end

  assign w_legal   = (w_sel_op <= c_OP_LAST);
  assign w_ptr_nxt = (w_gnt == c_ID_LAST) ? '0 : w_gnt + IDW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_req_ready = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_accept    = 1'b1;
          w_req_ready = NREQ'(1) << w_gnt;
          w_state_nxt = w_legal ? ST_EXEC : ST_DONE;
        end
      end
      ST_EXEC: w_state_nxt = ST_DONE;
      ST_DONE: begin
        if (bus.rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Illegal ops skip the ALU entirely and answer straight from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_id       <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_rsp_res  <= '0;
      r_rsp_id   <= '0;
      r_rsp_err  <= 1'b0;
      r_op_count <= '0;
    end else begin
      if (w_accept) begin
        r_id  <= w_gnt;
        r_ptr <= w_ptr_nxt;
        if (w_legal) begin
          r_alu_a  <= w_sel_a;
          r_alu_b  <= w_sel_b;
          r_alu_op <= w_sel_op;
        end else begin
          r_rsp_res <= '0;
          r_rsp_err <= 1'b1;
          r_rsp_id  <= w_gnt;
        end
      end
      if (r_state == ST_EXEC) begin
        r_rsp_res  <= alu_res;
        r_rsp_err  <= 1'b0;
        r_rsp_id   <= r_id;
        r_op_count <= r_op_count + 16'd1;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = (r_state == ST_DONE);
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_res   = r_rsp_res;
  assign bus.rsp_err   = r_rsp_err;
  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign alu_op        = r_alu_op;
  assign busy          = (r_state != ST_IDLE);
  assign op_count      = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alu_share_ctrl : directed vector bench for alu_share_ctrl with an ALU model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_share_ctrl;
  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [32:0] alu_res;
  logic        busy;
  logic [15:0] op_count;

  alu_share_ctrl_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

  alu_share_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_res  (alu_res),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] sx(input logic [31:0] x);
    return {x[31], x};
  endfunction

  // External ALU stand-in
  always_comb begin
    alu_res = '0;
    case (alu_op)
      3'b000:  alu_res = sx(alu_a) + sx(alu_b);
      3'b001:  alu_res = sx(alu_a) - sx(alu_b);
      3'b010:  alu_res = sx(alu_a & alu_b);
      3'b011:  alu_res = sx(alu_a | alu_b);
      3'b100:  alu_res = sx(~(alu_a | alu_b));
      default: alu_res = '0;
    endcase
  end

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [32:0] res;
    logic        err;
  } vec_t;

  vec_t vt[10];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
    bus.req_valid[id]          = 1'b1;
    bus.req_a[id*32 +: 32]     = a;
    bus.req_b[id*32 +: 32]     = b;
    bus.req_op[id*3 +: 3]      = op;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp_cnt;
    logic [2:0]  exp_aluop;
    logic [31:0] exp_alua;
    logic        legal;
    int          exp_order[6];
    int          g_cnt;
    int          r_cnt;
    int          last_g;

    vt[0] = '{0, 32'd5,          32'd7,          3'b000, 33'h0_0000000C, 1'b0};
    vt[1] = '{2, 32'd3,          32'd5,          3'b001, 33'h1_FFFFFFFE, 1'b0};
    vt[2] = '{1, 32'hF0F0_F0F0,  32'hFF00_FF00,  3'b010, 33'h1_F000F000, 1'b0};
    vt[3] = '{3, 32'h0000_00F0,  32'h0000_000F,  3'b011, 33'h0_000000FF, 1'b0};
    vt[4] = '{0, 32'h0F0F_0F0F,  32'h00FF_00FF,  3'b100, 33'h1_F000F000, 1'b0};
    vt[5] = '{1, 32'h7FFF_FFFF,  32'h0000_0001,  3'b000, 33'h0_80000000, 1'b0};
    vt[6] = '{2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  3'b000, 33'h1_FFFFFFFE, 1'b0};
    vt[7] = '{3, 32'd1,          32'd1,          3'b110, 33'h0_00000000, 1'b1};
    vt[8] = '{1, 32'd9,          32'd9,          3'b101, 33'h0_00000000, 1'b1};
    vt[9] = '{0, 32'h8000_0000,  32'h0000_0001,  3'b001, 33'h1_7FFFFFFF, 1'b0};
    exp_order = '{0, 1, 2, 3, 0, 1};

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("rst_alu_op",    64'(alu_op),        64'h0);
    chk("rst_alu_a",     64'(alu_a),         64'h0);
    chk("rst_rsp_res",   64'(bus.rsp_res),   64'h0);
    chk("rst_busy",      64'(busy),          64'h0);
    chk("rst_op_count",  64'(op_count),      64'h0);
    rst_n = 1'b1;
    tick();

    // Single-requester vectors, response accepted immediately
    exp_cnt   = '0;
    exp_aluop = '0;
    exp_alua  = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_req(vt[i].id, vt[i].a, vt[i].b, vt[i].op);
      #1;
      chk("vec_req_ready", 64'(bus.req_ready), 64'(4'b0001 << vt[i].id));
      tick();
      bus.req_valid = '0;
      legal = (vt[i].op <= 3'b100);
      if (legal) begin
        exp_cnt++;
        exp_aluop = vt[i].op;
        exp_alua  = vt[i].a;
        chk("vec_exec_busy",  64'(busy),          64'h1);
        chk("vec_exec_valid", 64'(bus.rsp_valid), 64'h0);
        chk("vec_alu_op",     64'(alu_op),        64'(exp_aluop));
        tick();
      end else begin
        chk("vec_alu_op_kept", 64'(alu_op), 64'(exp_aluop));
        chk("vec_alu_a_kept",  64'(alu_a),  64'(exp_alua));
      end
      chk("vec_rsp_valid", 64'(bus.rsp_valid), 64'h1);
      chk("vec_rsp_res",   64'(bus.rsp_res),   64'(vt[i].res));
      chk("vec_rsp_id",    64'(bus.rsp_id),    64'(vt[i].id));
      chk("vec_rsp_err",   64'(bus.rsp_err),   64'(vt[i].err));
      chk("vec_op_count",  64'(op_count),      64'(exp_cnt));
      tick();
      chk("vec_idle_valid", 64'(bus.rsp_valid), 64'h0);
      chk("vec_idle_busy",  64'(busy),          64'h0);
    end

    // Reset during EXEC of a nor op (pointer is nonzero beforehand)
    set_req(2, 32'h0, 32'h0, 3'b100);
    #1;
    tick();
    bus.req_valid = '0;
    chk("rx_exec_busy", 64'(busy), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rx_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("rx_busy",      64'(busy),          64'h0);
    chk("rx_alu_op",    64'(alu_op),        64'h0);
    chk("rx_alu_a",     64'(alu_a),         64'h0);
    chk("rx_rsp_res",   64'(bus.rsp_res),   64'h0);
    chk("rx_rsp_id",    64'(bus.rsp_id),    64'h0);
    chk("rx_rsp_err",   64'(bus.rsp_err),   64'h0);
    chk("rx_op_count",  64'(op_count),      64'h0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rx_no_rsp", 64'(bus.rsp_valid), 64'h0);
    end

    // Round robin with every requester valid continuously
    for (int i = 0; i < 4; i++) set_req(i, 32'(i + 1), 32'h10, 3'b000);
    g_cnt  = 0;
    r_cnt  = 0;
    last_g = 0;
    for (int cyc = 0; cyc < 60 && r_cnt < 6; cyc++) begin
      #1;
      if (bus.req_ready != '0 && g_cnt < 6) begin
        chk("rr_grant", 64'(bus.req_ready), 64'(4'b0001 << exp_order[g_cnt]));
        if (g_cnt > 0) chk("rr_gap", 64'(cyc - last_g), 64'd3);
        last_g = cyc;
        g_cnt++;
      end
      if (bus.rsp_valid) begin
        chk("rr_rsp_id",  64'(bus.rsp_id),  64'(exp_order[r_cnt]));
        chk("rr_rsp_res", 64'(bus.rsp_res), 64'(exp_order[r_cnt] + 17));
        r_cnt++;
      end
      if (r_cnt < 6) tick();
    end
    chk("rr_responses", 64'(r_cnt), 64'd6);
    chk("rr_op_count",  64'(op_count), 64'd6);
    bus.req_valid = '0;
    tick();
    chk("rr_idle_busy", 64'(busy), 64'h0);

    // Backpressure: response held while req1 waits
    bus.rsp_ready = 1'b0;
    set_req(0, 32'd10, 32'd20, 3'b000);
    #1;
    tick();
    bus.req_valid = '0;
    tick();
    set_req(1, 32'd1, 32'd2, 3'b011);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_valid",     64'(bus.rsp_valid), 64'h1);
      chk("bp_id",        64'(bus.rsp_id),    64'h0);
      chk("bp_res",       64'(bus.rsp_res),   64'h1E);
      chk("bp_req_ready", 64'(bus.req_ready), 64'h0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_fall_valid", 64'(bus.rsp_valid), 64'h0);
    chk("bp_req1_grant", 64'(bus.req_ready), 64'h2);
    tick();
    bus.req_valid = '0;
    tick();
    chk("bp2_valid", 64'(bus.rsp_valid), 64'h1);
    chk("bp2_id",    64'(bus.rsp_id),    64'h1);
    chk("bp2_res",   64'(bus.rsp_res),   64'h3);
    chk("bp2_err",   64'(bus.rsp_err),   64'h0);
    tick();
    chk("bp2_idle", 64'(busy), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
